// File: rtl/flag_pkg.sv
// flag_pkg: shared types and constants for the flag / interrupt controller.
//   ictl_state_t : interrupt sequencing states.
//   SYNC_MIN     : smallest legal synchronizer depth.
package flag_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAVE    = 3'd1,
    VECTOR  = 3'd2,
    ISR     = 3'd3,
    RESTORE = 3'd4
  } ictl_state_t;

  localparam int SYNC_MIN = 2;

endpackage

// File: rtl/flag_int_ctrl_if.sv
// flag_int_ctrl_if: bundle between the control unit / ALU (master) and the
// flag / interrupt controller (slave).
//   master drives : INTR, INSTR_DONE, C_IN, Z_IN, FLG_C_LD, FLG_C_SET,
//                   FLG_C_CLR, FLG_Z_LD, I_SET, I_CLR, RETI
//   slave drives  : C_FLAG, Z_FLAG, I_FLAG, SHAD_C, SHAD_Z, INT_ACK, IN_ISR
//                   (+ INT_COUNT[CNT_W-1:0] when INT_COUNT_EN is defined)
// Optional feature macro: INT_COUNT_EN.
interface flag_int_ctrl_if
`ifdef INT_COUNT_EN
  #(parameter int CNT_W = 8)
`endif
  ;
  logic INTR;
  logic INSTR_DONE;
  logic C_IN;
  logic Z_IN;
  logic FLG_C_LD;
  logic FLG_C_SET;
  logic FLG_C_CLR;
  logic FLG_Z_LD;
  logic I_SET;
  logic I_CLR;
  logic RETI;
  logic C_FLAG;
  logic Z_FLAG;
  logic I_FLAG;
  logic SHAD_C;
  logic SHAD_Z;
  logic INT_ACK;
  logic IN_ISR;
`ifdef INT_COUNT_EN
  logic [CNT_W-1:0] INT_COUNT;
`endif

  modport master (
    output INTR, INSTR_DONE, C_IN, Z_IN, FLG_C_LD, FLG_C_SET, FLG_C_CLR,
           FLG_Z_LD, I_SET, I_CLR, RETI,
    input  C_FLAG, Z_FLAG, I_FLAG, SHAD_C, SHAD_Z, INT_ACK, IN_ISR
`ifdef INT_COUNT_EN
    , input INT_COUNT
`endif
  );

  modport slave (
    input  INTR, INSTR_DONE, C_IN, Z_IN, FLG_C_LD, FLG_C_SET, FLG_C_CLR,
           FLG_Z_LD, I_SET, I_CLR, RETI,
    output C_FLAG, Z_FLAG, I_FLAG, SHAD_C, SHAD_Z, INT_ACK, IN_ISR
`ifdef INT_COUNT_EN
    , output INT_COUNT
`endif
  );

endinterface

// File: rtl/intr_sync_edge.sv
// intr_sync_edge: SYNC_STAGES-flop synchronizer for an asynchronous request
// followed by a rising-edge detector.
//   CLK        : system clock, rising edge
//   RST        : synchronous active-high reset, clears all flops
//   intr_async : asynchronous request input
//   rise_pulse : one-cycle pulse on each rising edge of the synchronized request
module intr_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic intr_async,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchronizer shift chain and one-cycle-delayed copy for edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], intr_async};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Built purely from flops, so the pulse is glitch-free.
  assign rise_pulse = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/flag_int_ctrl.sv
// flag_int_ctrl: owns the C, Z and I flags plus one-level shadow copies of
// C and Z, and sequences interrupt entry (save + vector) and return (restore).
//   CLK, RST : clock (rising edge) and synchronous active-high reset
//   bus      : flag_int_ctrl_if.slave -- ALU results and flag controls in,
//              live/shadow flags, INT_ACK and IN_ISR out
// Optional feature macro: INT_COUNT_EN adds INT_COUNT, a wrapping count of
// INT_ACK cycles.
// SAVE and RESTORE effects commit on the clock edge that enters the state,
// so the shadow is captured at the INSTR_DONE edge and the flags are restored
// at the RETI edge (visible the cycle after RETI).
module flag_int_ctrl
  import flag_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef INT_COUNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic           CLK,
  input  logic           RST,
  flag_int_ctrl_if.slave bus
);

  // Depths below the minimum are raised rather than rejected.
  localparam int SYNC_N = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;

  ictl_state_t state_r;
  logic        pend_r;
  logic        c_flag_r;
  logic        z_flag_r;
  logic        i_flag_r;
  logic        shad_c_r;
  logic        shad_z_r;
  logic        int_ack_r;
  logic        in_isr_r;
  logic        rise_s;
  logic        take_s;
  logic        restore_s;

  intr_sync_edge #(.SYNC_STAGES(SYNC_N)) u_sync (
    .CLK        (CLK),
    .RST        (RST),
    .intr_async (bus.INTR),
    .rise_pulse (rise_s)
  );

  // Interrupt accepted only from IDLE at an instruction boundary.
  assign take_s    = (state_r == IDLE) && pend_r && i_flag_r && bus.INSTR_DONE;
  // RETI only honoured inside the ISR body; elsewhere it is ignored.
  assign restore_s = (state_r == ISR) && bus.RETI;

  // Sequencer, pending request, live flags and shadow registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= IDLE;
      pend_r    <= 1'b0;
      c_flag_r  <= 1'b0;
      z_flag_r  <= 1'b0;
      i_flag_r  <= 1'b0;
      shad_c_r  <= 1'b0;
      shad_z_r  <= 1'b0;
      int_ack_r <= 1'b0;
      in_isr_r  <= 1'b0;
    end else begin
      // A fresh edge coinciding with consumption starts a new request.
      pend_r    <= rise_s | (pend_r & ~take_s);
      int_ack_r <= 1'b0;

      case (state_r)
        IDLE: begin
          if (take_s) begin
            state_r  <= SAVE;
            shad_c_r <= c_flag_r;
            shad_z_r <= z_flag_r;
          end else begin
            state_r  <= IDLE;
          end
        end
        SAVE: begin
          state_r   <= VECTOR;
          int_ack_r <= 1'b1;
          in_isr_r  <= 1'b1;
        end
        VECTOR: begin
          state_r <= ISR;
        end
        ISR: begin
          if (restore_s) begin
            state_r <= RESTORE;
          end else begin
            state_r <= ISR;
          end
        end
        RESTORE: begin
          state_r  <= IDLE;
          in_isr_r <= 1'b0;
        end
        default: begin
          state_r  <= IDLE;
          in_isr_r <= 1'b0;
        end
      endcase

      if (restore_s) begin
        c_flag_r <= shad_c_r;
      end else if (bus.FLG_C_CLR) begin
        c_flag_r <= 1'b0;
      end else if (bus.FLG_C_SET) begin
        c_flag_r <= 1'b1;
      end else if (bus.FLG_C_LD) begin
        c_flag_r <= bus.C_IN;
      end else begin
        c_flag_r <= c_flag_r;
      end

      if (restore_s) begin
        z_flag_r <= shad_z_r;
      end else if (bus.FLG_Z_LD) begin
        z_flag_r <= bus.Z_IN;
      end else begin
        z_flag_r <= z_flag_r;
      end

      if (take_s) begin
        i_flag_r <= 1'b0;
      end else if (restore_s) begin
        i_flag_r <= 1'b1;
      end else if (bus.I_CLR) begin
        i_flag_r <= 1'b0;
      end else if (bus.I_SET) begin
        i_flag_r <= 1'b1;
      end else begin
        i_flag_r <= i_flag_r;
      end
    end
  end

  assign bus.C_FLAG  = c_flag_r;
  assign bus.Z_FLAG  = z_flag_r;
  assign bus.I_FLAG  = i_flag_r;
  assign bus.SHAD_C  = shad_c_r;
  assign bus.SHAD_Z  = shad_z_r;
  assign bus.INT_ACK = int_ack_r;
  assign bus.IN_ISR  = in_isr_r;

`ifdef INT_COUNT_EN
  logic [CNT_W-1:0] int_cnt_r;

  // Count acknowledged interrupts; natural wrap from all-ones to zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      int_cnt_r <= {CNT_W{1'b0}};
    end else if (int_ack_r) begin
      int_cnt_r <= int_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      int_cnt_r <= int_cnt_r;
    end
  end

  assign bus.INT_COUNT = int_cnt_r;
`endif

endmodule

// File: tb/tb_flag_int_ctrl.sv
// tb_flag_int_ctrl: directed sequence covering the test plan followed by a
// randomized phase; every cycle the DUT outputs are compared against a
// cycle-level behavioural model of the flag / interrupt rules.
module tb_flag_int_ctrl;

  localparam int SYNC = 3;
  localparam int CNT  = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  int ncmp  = 0;
  int nfail = 0;

`ifdef INT_COUNT_EN
  flag_int_ctrl_if #(.CNT_W(CNT)) bus ();
  flag_int_ctrl #(.SYNC_STAGES(SYNC), .CNT_W(CNT)) dut (.CLK(CLK), .RST(RST), .bus(bus));
`else
  flag_int_ctrl_if bus ();
  flag_int_ctrl #(.SYNC_STAGES(SYNC)) dut (.CLK(CLK), .RST(RST), .bus(bus));
`endif

  always #5 CLK = ~CLK;

  // Reference model state. m_age: -1 idle, 0 just accepted, 1 acking,
  // 2 inside the ISR body, -2 returning (one cycle before idle again).
  logic m_c, m_z, m_i, m_sc, m_sz, m_pend, m_ack, m_isr;
  int   m_age;
  int   m_cnt;
  logic hist[$];   // sampled INTR values, newest first

  task automatic chk(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    {m_c, m_z, m_i, m_sc, m_sz, m_pend, m_ack, m_isr} = 8'h00;
    m_age = -1;
    m_cnt = 0;
    hist = {};
    repeat (SYNC + 1) hist.push_back(1'b0);
  endtask

  // One clock: advance the model with the inputs seen at the edge, then check.
  task automatic step();
    logic pulse, take, rest, c0, z0, ack0;
    @(posedge CLK);
    if (RST) begin
      model_reset();
    end else begin
      pulse = hist[SYNC-1] & ~hist[SYNC];
      hist.push_front(bus.INTR);
      void'(hist.pop_back());
      take = (m_age == -1) && m_pend && m_i && bus.INSTR_DONE;
      rest = (m_age >= 2) && bus.RETI;
      c0 = m_c;
      z0 = m_z;
      ack0 = m_ack;
      m_ack = (m_age == 0);
      if (m_age == 0) m_isr = 1'b1;
      else if (m_age == -2) m_isr = 1'b0;
      if (rest) m_c = m_sc;
      else if (bus.FLG_C_CLR) m_c = 1'b0;
      else if (bus.FLG_C_SET) m_c = 1'b1;
      else if (bus.FLG_C_LD) m_c = bus.C_IN;
      if (rest) m_z = m_sz;
      else if (bus.FLG_Z_LD) m_z = bus.Z_IN;
      if (take) m_i = 1'b0;
      else if (rest) m_i = 1'b1;
      else if (bus.I_CLR) m_i = 1'b0;
      else if (bus.I_SET) m_i = 1'b1;
      if (take) begin
        m_sc = c0;
        m_sz = z0;
      end
      m_pend = pulse | (m_pend & ~take);
      if (take) m_age = 0;
      else if (m_age == 0 || m_age == 1) m_age++;
      else if (rest) m_age = -2;
      else if (m_age == -2) m_age = -1;
      if (ack0) m_cnt = (m_cnt + 1) % (1 << CNT);
    end
    #1;
    chk("c_flag", bus.C_FLAG, m_c);
    chk("z_flag", bus.Z_FLAG, m_z);
    chk("i_flag", bus.I_FLAG, m_i);
    chk("shad_c", bus.SHAD_C, m_sc);
    chk("shad_z", bus.SHAD_Z, m_sz);
    chk("int_ack", bus.INT_ACK, m_ack);
    chk("in_isr", bus.IN_ISR, m_isr);
`ifdef INT_COUNT_EN
    ncmp++;
    assert (bus.INT_COUNT === CNT'(m_cnt)) else begin
      nfail++;
      $error("FAIL int_count: observed %0d expected %0d", bus.INT_COUNT, m_cnt);
    end
`endif
  endtask

  task automatic clear_inputs();
    {bus.INTR, bus.INSTR_DONE, bus.C_IN, bus.Z_IN, bus.FLG_C_LD, bus.FLG_C_SET,
     bus.FLG_C_CLR, bus.FLG_Z_LD, bus.I_SET, bus.I_CLR, bus.RETI} = 11'h000;
  endtask

  // Single-cycle INTR pulse, then enough cycles for it to reach PEND.
  task automatic intr_edge();
    bus.INTR = 1'b1;
    step();
    bus.INTR = 1'b0;
    repeat (SYNC + 1) step();
  endtask

  // INSTR_DONE boundary that must be accepted: ACK two edges later.
  task automatic take_expect_ack(input string tag);
    bus.INSTR_DONE = 1'b1;
    step();
    bus.INSTR_DONE = 1'b0;
    chk({tag, "_ack_early"}, bus.INT_ACK, 1'b0);
    step();
    chk({tag, "_ack"}, bus.INT_ACK, 1'b1);
    chk({tag, "_in_isr"}, bus.IN_ISR, 1'b1);
    step();
    chk({tag, "_ack_len"}, bus.INT_ACK, 1'b0);
  endtask

  task automatic do_reti();
    bus.RETI = 1'b1;
    step();
    bus.RETI = 1'b0;
    step();
  endtask

  initial begin
    model_reset();
    // 1. Reset with every input high.
    {bus.INTR, bus.INSTR_DONE, bus.C_IN, bus.Z_IN, bus.FLG_C_LD, bus.FLG_C_SET,
     bus.FLG_C_CLR, bus.FLG_Z_LD, bus.I_SET, bus.I_CLR, bus.RETI} = 11'h7FF;
    RST = 1'b1;
    step();
    step();
    chk("rst_c", bus.C_FLAG, 1'b0);
    chk("rst_i", bus.I_FLAG, 1'b0);
    chk("rst_ack", bus.INT_ACK, 1'b0);
    chk("rst_isr", bus.IN_ISR, 1'b0);
    RST = 1'b0;
    clear_inputs();
    step();

    // 2. Basic ISR.
    bus.I_SET = 1'b1;
    step();
    bus.I_SET = 1'b0;
    bus.C_IN = 1'b1; bus.FLG_C_LD = 1'b1; bus.Z_IN = 1'b0; bus.FLG_Z_LD = 1'b1;
    step();
    clear_inputs();
    intr_edge();
    bus.INSTR_DONE = 1'b1;
    step();
    bus.INSTR_DONE = 1'b0;
    chk("basic_shad_c", bus.SHAD_C, 1'b1);
    chk("basic_shad_z", bus.SHAD_Z, 1'b0);
    chk("basic_i_clr", bus.I_FLAG, 1'b0);
    chk("basic_ack_t1", bus.INT_ACK, 1'b0);
    step();
    chk("basic_ack_t2", bus.INT_ACK, 1'b1);
    step();
    bus.FLG_C_CLR = 1'b1; bus.FLG_Z_LD = 1'b1; bus.Z_IN = 1'b1;
    step();
    clear_inputs();
    chk("body_c", bus.C_FLAG, 1'b0);
    chk("body_z", bus.Z_FLAG, 1'b1);
    bus.RETI = 1'b1;
    step();
    bus.RETI = 1'b0;
    chk("ret_c", bus.C_FLAG, 1'b1);
    chk("ret_z", bus.Z_FLAG, 1'b0);
    chk("ret_i", bus.I_FLAG, 1'b1);
    chk("ret_isr_hold", bus.IN_ISR, 1'b1);
    step();
    chk("ret_isr_drop", bus.IN_ISR, 1'b0);

    // 3. Masked request is held, then taken after SEI.
    bus.I_CLR = 1'b1;
    step();
    bus.I_CLR = 1'b0;
    intr_edge();
    for (int k = 0; k < 5; k++) begin
      bus.INSTR_DONE = 1'b1;
      step();
      bus.INSTR_DONE = 1'b0;
      step();
      chk("masked_no_ack", bus.INT_ACK, 1'b0);
    end
    bus.I_SET = 1'b1;
    step();
    bus.I_SET = 1'b0;
    take_expect_ack("unmask");

    // 4. Edge during the ISR (SEI too) is serviced only after return.
    intr_edge();
    bus.I_SET = 1'b1;
    step();
    bus.I_SET = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.INSTR_DONE = 1'b1;
      step();
      bus.INSTR_DONE = 1'b0;
      step();
      chk("isr_no_ack", bus.INT_ACK, 1'b0);
    end
    do_reti();
    take_expect_ack("after_ret");
    do_reti();

    // 5. Priority of C updates.
    bus.FLG_C_CLR = 1'b1; bus.FLG_C_SET = 1'b1; bus.FLG_C_LD = 1'b1; bus.C_IN = 1'b1;
    step();
    clear_inputs();
    chk("prio_clr", bus.C_FLAG, 1'b0);
    intr_edge();
    take_expect_ack("prio");
    chk("prio_shad_c", bus.SHAD_C, 1'b0);
    bus.FLG_C_SET = 1'b1;
    step();
    bus.RETI = 1'b1;
    step();
    clear_inputs();
    chk("prio_restore", bus.C_FLAG, 1'b0);
    step();

    // 6. Stray RETI, then reset inside an ISR.
    bus.FLG_C_SET = 1'b1;
    step();
    bus.FLG_C_SET = 1'b0;
    bus.RETI = 1'b1;
    step();
    bus.RETI = 1'b0;
    chk("stray_c", bus.C_FLAG, 1'b1);
    chk("stray_i", bus.I_FLAG, 1'b1);
    intr_edge();
    take_expect_ack("pre_rst");
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rst_isr_in_isr", bus.IN_ISR, 1'b0);
    chk("rst_isr_i", bus.I_FLAG, 1'b0);
    intr_edge();
    bus.INSTR_DONE = 1'b1;
    step();
    bus.INSTR_DONE = 1'b0;
    step();
    chk("rst_needs_sei", bus.INT_ACK, 1'b0);
    bus.I_SET = 1'b1;
    step();
    bus.I_SET = 1'b0;
    take_expect_ack("post_rst");
    do_reti();

`ifdef INT_COUNT_EN
    RST = 1'b1;
    step();
    RST = 1'b0;
    bus.I_SET = 1'b1;
    step();
    bus.I_SET = 1'b0;
    for (int k = 0; k < (1 << CNT); k++) begin
      intr_edge();
      take_expect_ack("cnt");
      do_reti();
    end
    ncmp++;
    assert (bus.INT_COUNT === {CNT{1'b0}}) else begin
      nfail++;
      $error("FAIL int_count_wrap: observed %0d expected 0", bus.INT_COUNT);
    end
`endif

    // Randomized phase checked against the model every cycle.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 5) == 0) bus.INTR = ~bus.INTR;
      bus.INSTR_DONE = ($urandom_range(0, 2) == 0);
      bus.C_IN       = 1'($urandom_range(0, 1));
      bus.Z_IN       = 1'($urandom_range(0, 1));
      bus.FLG_C_LD   = ($urandom_range(0, 3) == 0);
      bus.FLG_C_SET  = ($urandom_range(0, 5) == 0);
      bus.FLG_C_CLR  = ($urandom_range(0, 5) == 0);
      bus.FLG_Z_LD   = ($urandom_range(0, 3) == 0);
      bus.I_SET      = ($urandom_range(0, 3) == 0);
      bus.I_CLR      = ($urandom_range(0, 9) == 0);
      bus.RETI       = ($urandom_range(0, 5) == 0);
      RST            = ($urandom_range(0, 199) == 0);
      step();
    end
    RST = 1'b0;
    clear_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/flag_int_ctrl.md
Name: flag_int_ctrl

Overview:
Owns the CPU status flags: C, Z and the interrupt-enable flag I, plus their one-level shadow copies. Sequences interrupt entry and return around those flags. It detects an external interrupt request and waits for an instruction boundary. At that boundary it saves C and Z to the shadow registers, clears I and signals the control unit to vector. On RETI it restores C and Z from the shadow registers and re-enables interrupts. It sits between the control unit / ALU and the control unit's interrupt-vector logic.

Parameters:
SYNC_STAGES, 2, number of flops in the INTR synchronizer (minimum 2).
CNT_W, 8, width of the interrupt counter (optional feature only).

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  synchronous, active-high reset.
INTR  in  1  asynchronous external interrupt request; a rising edge requests service.
INSTR_DONE  in  1  one-cycle pulse from the CU marking an instruction boundary.
C_IN  in  1  carry result from the ALU.
Z_IN  in  1  zero result from the ALU.
FLG_C_LD  in  1  load C from C_IN.
FLG_C_SET  in  1  set C.
FLG_C_CLR  in  1  clear C.
FLG_Z_LD  in  1  load Z from Z_IN.
I_SET  in  1  SEI instruction.
I_CLR  in  1  CLI instruction.
RETI  in  1  one-cycle pulse, return-from-interrupt executing.
C_FLAG  out  1  live carry flag.
Z_FLAG  out  1  live zero flag.
I_FLAG  out  1  interrupt enable.
SHAD_C  out  1  shadow carry.
SHAD_Z  out  1  shadow zero.
INT_ACK  out  1  one-cycle pulse; CU pushes PC and loads the vector.
IN_ISR  out  1  high from INT_ACK until restore completes.

Behaviour:
- Reset (RST=1 at a rising edge), all cleared to 0: every output, the synchronizer, the edge detector, the pending bit and the FSM (state IDLE). Reset mid-ISR abandons the ISR. Any pending request is discarded.
- Request detection:
  - INTR passes through SYNC_STAGES flops; a rising edge of the synchronized signal sets PEND.
  - PEND stays set until consumed in SAVE.
  - Further edges while PEND=1 are merged into the same request.
  - Edges during the ISR set PEND, which is serviced after return.
- FSM states:
  - IDLE:
    - Go to SAVE when PEND & I_FLAG & INSTR_DONE in the same cycle.
    - If I_FLAG=0, PEND is held, not dropped.
  - SAVE (1 cycle):
    - SHAD_C <= C_FLAG and SHAD_Z <= Z_FLAG, using the values before this edge.
    - I_FLAG <= 0 and PEND <= 0. Go to VECTOR.
  - VECTOR (1 cycle): INT_ACK=1 and IN_ISR=1. Go to ISR.
  - ISR:
    - IN_ISR=1. Interrupts are never taken here, even if software executes SEI; there is only one shadow level.
    - RETI=1 goes to RESTORE.
  - RESTORE (1 cycle):
    - C_FLAG <= SHAD_C, Z_FLAG <= SHAD_Z, I_FLAG <= 1.
    - Go to IDLE; IN_ISR drops on the following cycle.
  - RETI outside ISR is ignored; no flag change.
- Live flag update priority, per edge:
  - C_FLAG: RESTORE > CLR > SET > LD > hold.
  - Z_FLAG: RESTORE > LD > hold.
  - I_FLAG: SAVE clear > RESTORE set > I_CLR > I_SET > hold.
  - ALU loads in SAVE/VECTOR still update the live flags; the shadow keeps the pre-SAVE values.
- Latency:
  - INTR rising edge to PEND: SYNC_STAGES+1 cycles.
  - INSTR_DONE (with PEND & I_FLAG) to INT_ACK: 2 cycles.
  - RETI to flags restored: 1 cycle.

Optional Feature:
INT_COUNT_EN
- Defined: adds output INT_COUNT [CNT_W-1:0], which increments on every INT_ACK cycle, wraps from all-ones to 0, and resets to 0.
- Undefined: no port, no counter logic; behaviour is otherwise identical.

Decomposition:
- Shared package flag_pkg:
  - enum ictl_state_t {IDLE, SAVE, VECTOR, ISR, RESTORE}.
  - localparam SYNC_MIN = 2.
- Sub-module intr_sync_edge: SYNC_STAGES-flop synchronizer plus rising-edge detector, with a 1-cycle pulse output. Flag and shadow registers stay inline.

Test Plan:
1. Reset: RST=1 for 2 cycles with all inputs at 1 -> all outputs 0 and state IDLE.
2. Basic ISR:
   - Stimulus: SEI, set C=1 and Z=0 via LD, pulse INTR, then INSTR_DONE.
   - Entry: after INSTR_DONE, SHAD_C=1 and SHAD_Z=0, I_FLAG=0, and INT_ACK pulses exactly 2 cycles after INSTR_DONE.
   - Body: in the ISR, FLG_C_CLR and FLG_Z_LD with Z_IN=1 -> C=0, Z=1.
   - Return: RETI -> next cycle C=1, Z=0, I=1, and IN_ISR=0 one cycle later.
3. Masked request: I_FLAG=0, INTR edge and 5 INSTR_DONE pulses -> no INT_ACK; then SEI and INSTR_DONE -> INT_ACK.
4. Edge during ISR: second INTR edge while IN_ISR=1 -> no ACK until after RETI; the next INSTR_DONE yields INT_ACK.
5. Priority: simultaneous FLG_C_CLR/SET/LD with C_IN=1 -> C=0. RESTORE cycle with FLG_C_SET=1 and SHAD_C=0 -> C=0.
6. Stray/reset: RETI in IDLE -> no flag change. RST asserted in ISR -> IN_ISR=0, I=0, and the next INTR requires SEI. With INT_COUNT_EN, 256 ACKs with CNT_W=8 -> INT_COUNT=0.
